// File: rtl/mips_ctrl_pkg.sv
//----------------------------------------------------------------------------
// Module  : mips_ctrl_pkg
// Brief   : Shared encodings for the multicycle MIPS control path.
// Rev     : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC     = 4'd6,
    S_RWB      = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_ADDIEX   = 4'd10,
    S_ADDIWB   = 4'd11,
    S_JAL      = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  // Shared with ALU_control; 2'b11 is reserved and never driven.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] REGDST_RT = 2'b00;
  localparam logic [1:0] REGDST_RD = 2'b01;
  localparam logic [1:0] REGDST_RA = 2'b10;

  localparam logic [1:0] MEMTOREG_ALUOUT = 2'b00;
  localparam logic [1:0] MEMTOREG_MDR    = 2'b01;
  localparam logic [1:0] MEMTOREG_PC     = 2'b10;

  localparam logic [1:0] ALUSRCB_B       = 2'b00;
  localparam logic [1:0] ALUSRCB_FOUR    = 2'b01;
  localparam logic [1:0] ALUSRCB_IMM     = 2'b10;
  localparam logic [1:0] ALUSRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

endpackage

`default_nettype wire

// File: rtl/multicycle_control_if.sv
//----------------------------------------------------------------------------
// Module  : multicycle_control_if
// Brief   : Control bundle between the main FSM (master) and the datapath.
// Rev     : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

interface multicycle_control_if;

  logic [5:0] opcode;
  logic       zero;
  logic       mem_ready;

  logic       PCWrite;
  logic       IorD;
  logic       MemRead;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegWrite;
  logic [1:0] RegDst;
  logic [1:0] MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [1:0] ALUOp;
  logic [1:0] PCSource;
  logic       instr_done;
  logic       illegal_op;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst,
           MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done,
           illegal_op, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  PCWrite, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst,
           MemtoReg, ALUSrcA, ALUSrcB, ALUOp, PCSource, instr_done,
           illegal_op, state
  );

endinterface

`default_nettype wire

// File: rtl/multicycle_control.sv
//----------------------------------------------------------------------------
// Module  : multicycle_control
// Brief   : Main control FSM of the multicycle MIPS core.
// Rev     : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module multicycle_control
  import mips_ctrl_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst,
  multicycle_control_if.master        bus
);

  state_t     r_state;
  state_t     w_next_state;

  logic       w_pc_write;
  logic       w_iord;
  logic       w_mem_read;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic [1:0] w_reg_dst;
  logic [1:0] w_mem_to_reg;
  logic       w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [1:0] w_pc_source;
  logic       w_instr_done;
  logic       w_illegal_op;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = S_FETCH;
    case (r_state)
      S_FETCH:    w_next_state = bus.mem_ready ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (bus.opcode)
          OP_LW, OP_SW:    w_next_state = S_MEMADDR;
          OP_RTYPE:        w_next_state = S_EXEC;
          OP_BEQ, OP_BNE:  w_next_state = S_BRANCH;
          OP_ADDI:         w_next_state = S_ADDIEX;
          OP_J:            w_next_state = S_JUMP;
          OP_JAL:          w_next_state = S_JAL;
          default:         w_next_state = S_FETCH;
        endcase
      end
      S_MEMADDR:  w_next_state = (bus.opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  w_next_state = bus.mem_ready ? S_MEMWB : S_MEMREAD;
      S_MEMWRITE: w_next_state = bus.mem_ready ? S_FETCH : S_MEMWRITE;
      S_EXEC:     w_next_state = S_RWB;
      S_ADDIEX:   w_next_state = S_ADDIWB;
      default:    w_next_state = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_write   = 1'b0;
    w_iord       = 1'b0;
    w_mem_read   = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_reg_dst    = REGDST_RT;
    w_mem_to_reg = MEMTOREG_ALUOUT;
    w_alu_src_a  = 1'b0;
    w_alu_src_b  = ALUSRCB_B;
    w_alu_op     = ALUOP_ADD;
    w_pc_source  = PCSRC_ALU;
    w_instr_done = 1'b0;
    w_illegal_op = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_mem_read  = 1'b1;
        w_alu_src_b = ALUSRCB_FOUR;
        w_pc_source = PCSRC_ALU;
        w_ir_write  = bus.mem_ready;
        w_pc_write  = bus.mem_ready;
      end
      S_DECODE: begin
        w_alu_src_b = ALUSRCB_IMM_SH2;
        case (bus.opcode)
          OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J, OP_JAL: ;
          default: begin
            w_illegal_op = 1'b1;
            w_instr_done = 1'b1;
          end
        endcase
      end
      S_MEMADDR, S_ADDIEX: begin
        w_alu_src_a = 1'b1;
        w_alu_src_b = ALUSRCB_IMM;
      end
      S_MEMREAD: begin
        w_iord     = 1'b1;
        w_mem_read = 1'b1;
      end
      S_MEMWB: begin
        w_reg_write  = 1'b1;
        w_mem_to_reg = MEMTOREG_MDR;
        w_instr_done = 1'b1;
      end
      S_MEMWRITE: begin
        w_iord       = 1'b1;
        w_mem_write  = 1'b1;
        w_instr_done = bus.mem_ready;
      end
      S_EXEC: begin
        w_alu_src_a = 1'b1;
        w_alu_op    = ALUOP_FUNCT;
      end
      S_RWB: begin
        w_reg_write  = 1'b1;
        w_reg_dst    = REGDST_RD;
        w_instr_done = 1'b1;
      end
      S_BRANCH: begin
        // opcode[0] distinguishes bne from beq and inverts the taken sense.
        w_alu_src_a  = 1'b1;
        w_alu_op     = ALUOP_SUB;
        w_pc_source  = PCSRC_ALUOUT;
        w_pc_write   = bus.zero ^ bus.opcode[0];
        w_instr_done = 1'b1;
      end
      S_ADDIWB: begin
        w_reg_write  = 1'b1;
        w_instr_done = 1'b1;
      end
      S_JUMP: begin
        w_pc_source  = PCSRC_JUMP;
        w_pc_write   = 1'b1;
        w_instr_done = 1'b1;
      end
      S_JAL: begin
        w_pc_source  = PCSRC_JUMP;
        w_pc_write   = 1'b1;
        w_reg_write  = 1'b1;
        w_reg_dst    = REGDST_RA;
        w_mem_to_reg = MEMTOREG_PC;
        w_instr_done = 1'b1;
      end
      default: ;
    endcase
    // Write enables and pulses are masked for the whole reset window.
    if (rst) begin
      w_pc_write   = 1'b0;
      w_ir_write   = 1'b0;
      w_reg_write  = 1'b0;
      w_mem_write  = 1'b0;
      w_instr_done = 1'b0;
      w_illegal_op = 1'b0;
    end
  end

  assign bus.PCWrite    = w_pc_write;
  assign bus.IorD       = w_iord;
  assign bus.MemRead    = w_mem_read;
  assign bus.MemWrite   = w_mem_write;
  assign bus.IRWrite    = w_ir_write;
  assign bus.RegWrite   = w_reg_write;
  assign bus.RegDst     = w_reg_dst;
  assign bus.MemtoReg   = w_mem_to_reg;
  assign bus.ALUSrcA    = w_alu_src_a;
  assign bus.ALUSrcB    = w_alu_src_b;
  assign bus.ALUOp      = w_alu_op;
  assign bus.PCSource   = w_pc_source;
  assign bus.instr_done = w_instr_done;
  assign bus.illegal_op = w_illegal_op;
  assign bus.state      = r_state;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_control.sv
//----------------------------------------------------------------------------
// Module  : tb_multicycle_control
// Brief   : Directed self-checking bench for the multicycle control FSM.
// Rev     : 1.0  initial release
//----------------------------------------------------------------------------
`default_nettype none

module tb_multicycle_control;

  localparam logic [5:0] C_RT  = 6'b000000;
  localparam logic [5:0] C_LW  = 6'b100011;
  localparam logic [5:0] C_SW  = 6'b101011;
  localparam logic [5:0] C_BEQ = 6'b000100;
  localparam logic [5:0] C_BNE = 6'b000101;
  localparam logic [5:0] C_ADI = 6'b001000;
  localparam logic [5:0] C_J   = 6'b000010;
  localparam logic [5:0] C_JAL = 6'b000011;
  localparam logic [5:0] C_BAD = 6'b111111;

  typedef struct packed {
    logic [3:0] state;
    logic       pc_write, iord, mem_read, mem_write, ir_write, reg_write;
    logic [1:0] reg_dst, mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b, alu_op, pc_source;
    logic       instr_done, illegal_op;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  multicycle_control_if bus();

  multicycle_control dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Expected outputs per state, written from the control table.
  function automatic exp_t ref_out(int st, logic [5:0] opc, logic z, logic rdy, logic rs);
    exp_t e;
    e = '0;
    e.state = st[3:0];
    case (st)
      0:  begin e.mem_read = 1; e.alu_src_b = 2'b01; e.ir_write = rdy; e.pc_write = rdy; end
      1:  begin
            e.alu_src_b = 2'b11;
            if (!(opc inside {C_RT, C_LW, C_SW, C_BEQ, C_BNE, C_ADI, C_J, C_JAL})) begin
              e.illegal_op = 1; e.instr_done = 1;
            end
          end
      2:  begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      3:  begin e.iord = 1; e.mem_read = 1; end
      4:  begin e.reg_write = 1; e.mem_to_reg = 2'b01; e.instr_done = 1; end
      5:  begin e.iord = 1; e.mem_write = 1; e.instr_done = rdy; end
      6:  begin e.alu_src_a = 1; e.alu_op = 2'b10; end
      7:  begin e.reg_write = 1; e.reg_dst = 2'b01; e.instr_done = 1; end
      8:  begin
            e.alu_src_a = 1; e.alu_op = 2'b01; e.pc_source = 2'b01;
            e.pc_write = z ^ opc[0]; e.instr_done = 1;
          end
      9:  begin e.pc_source = 2'b10; e.pc_write = 1; e.instr_done = 1; end
      10: begin e.alu_src_a = 1; e.alu_src_b = 2'b10; end
      11: begin e.reg_write = 1; e.instr_done = 1; end
      12: begin
            e.pc_source = 2'b10; e.pc_write = 1; e.reg_write = 1;
            e.reg_dst = 2'b10; e.mem_to_reg = 2'b10; e.instr_done = 1;
          end
      default: ;
    endcase
    if (rs) begin
      e.pc_write = 0; e.ir_write = 0; e.reg_write = 0;
      e.mem_write = 0; e.instr_done = 0; e.illegal_op = 0;
    end
    return e;
  endfunction

  function automatic exp_t observed();
    exp_t o;
    o.state      = bus.state;
    o.pc_write   = bus.PCWrite;
    o.iord       = bus.IorD;
    o.mem_read   = bus.MemRead;
    o.mem_write  = bus.MemWrite;
    o.ir_write   = bus.IRWrite;
    o.reg_write  = bus.RegWrite;
    o.reg_dst    = bus.RegDst;
    o.mem_to_reg = bus.MemtoReg;
    o.alu_src_a  = bus.ALUSrcA;
    o.alu_src_b  = bus.ALUSrcB;
    o.alu_op     = bus.ALUOp;
    o.pc_source  = bus.PCSource;
    o.instr_done = bus.instr_done;
    o.illegal_op = bus.illegal_op;
    return o;
  endfunction

  task automatic compare_pop(input string tag);
    exp_t e;
    exp_t o;
    e = exp_q.pop_front();
    o = observed();
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, o, e);
    end
  endtask

  // One clock cycle: drive after the rising edge, check on the falling edge.
  task automatic step(input string tag, input logic [5:0] opc, input logic z,
                      input logic rdy, input int st);
    bus.opcode    = opc;
    bus.zero      = z;
    bus.mem_ready = rdy;
    exp_q.push_back(ref_out(st, opc, z, rdy, rst));
    @(negedge clk);
    compare_pop(tag);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.opcode    = C_LW;
    bus.zero      = 1'b0;
    bus.mem_ready = 1'b1;
    #3;
    exp_q.push_back(ref_out(0, C_LW, 1'b0, 1'b1, 1'b1));
    compare_pop("reset");
    @(posedge clk);
    #1;
    step("reset_hold", C_LW, 1'b0, 1'b1, 0);
    rst = 1'b0;

    step("lw_fetch", C_LW, 1'b0, 1'b1, 0);
    step("lw_decode", C_LW, 1'b0, 1'b1, 1);
    step("lw_memaddr", C_LW, 1'b0, 1'b1, 2);
    step("lw_memread", C_LW, 1'b0, 1'b1, 3);
    step("lw_memwb", C_LW, 1'b0, 1'b1, 4);

    step("sw_fetch", C_SW, 1'b0, 1'b1, 0);
    step("sw_decode", C_SW, 1'b0, 1'b1, 1);
    step("sw_memaddr", C_SW, 1'b0, 1'b1, 2);
    for (int i = 0; i < 3; i++) step("sw_stall", C_SW, 1'b0, 1'b0, 5);
    step("sw_ready", C_SW, 1'b0, 1'b1, 5);

    step("r_fetch_stall", C_RT, 1'b0, 1'b0, 0);
    step("r_fetch", C_RT, 1'b0, 1'b1, 0);
    step("r_decode", C_RT, 1'b0, 1'b1, 1);
    step("r_exec", C_RT, 1'b0, 1'b1, 6);
    step("r_rwb", C_RT, 1'b0, 1'b1, 7);

    step("beq_fetch", C_BEQ, 1'b1, 1'b1, 0);
    step("beq_decode", C_BEQ, 1'b1, 1'b1, 1);
    step("beq_z1", C_BEQ, 1'b1, 1'b1, 8);
    step("bne_fetch", C_BNE, 1'b1, 1'b1, 0);
    step("bne_decode", C_BNE, 1'b1, 1'b1, 1);
    step("bne_z1", C_BNE, 1'b1, 1'b1, 8);
    step("bne2_fetch", C_BNE, 1'b0, 1'b1, 0);
    step("bne2_decode", C_BNE, 1'b0, 1'b1, 1);
    step("bne_z0", C_BNE, 1'b0, 1'b1, 8);

    step("addi_fetch", C_ADI, 1'b0, 1'b1, 0);
    step("addi_decode", C_ADI, 1'b0, 1'b1, 1);
    step("addi_ex", C_ADI, 1'b0, 1'b1, 10);
    step("addi_wb", C_ADI, 1'b0, 1'b1, 11);

    step("j_fetch", C_J, 1'b0, 1'b1, 0);
    step("j_decode", C_J, 1'b0, 1'b1, 1);
    step("j_jump", C_J, 1'b0, 1'b1, 9);
    step("jal_fetch", C_JAL, 1'b0, 1'b1, 0);
    step("jal_decode", C_JAL, 1'b0, 1'b1, 1);
    step("jal_jal", C_JAL, 1'b0, 1'b1, 12);

    step("bad_fetch", C_BAD, 1'b0, 1'b1, 0);
    step("bad_decode", C_BAD, 1'b0, 1'b1, 1);
    step("bad_back", C_BAD, 1'b0, 1'b1, 0);

    step("lw2_decode", C_LW, 1'b0, 1'b1, 1);
    step("lw2_memaddr", C_LW, 1'b0, 1'b1, 2);
    step("lw2_stall", C_LW, 1'b0, 1'b0, 3);
    // Reset arrives mid-cycle while the read is still stalled.
    rst = 1'b1;
    exp_q.push_back(ref_out(0, C_LW, 1'b0, 1'b0, 1'b1));
    #2;
    compare_pop("reset_mid_stall");
    @(posedge clk);
    #1;
    rst = 1'b0;
    step("post_fetch", C_J, 1'b0, 1'b1, 0);
    step("post_decode", C_J, 1'b0, 1'b1, 1);
    step("post_jump", C_J, 1'b0, 1'b1, 9);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
